// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush strobes, registered E-stage forwarding selects, memory wait-state FSM.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_E,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic             PCSrcE,
  input  logic             mem_busy,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_ctr, wait_ctr_nxt;
  logic            hold_all;
  logic            load_use;
  logic [1:0]      fa_nxt, fb_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_ctr <= '0;
    end else begin
      state    <= state_nxt;
      wait_ctr <= wait_ctr_nxt;
    end
  end

  // The counter tracks consecutive busy cycles; the RUN->WAIT cycle counts as the first.
  always_comb begin
    state_nxt    = state;
    wait_ctr_nxt = wait_ctr;
    case (state)
      RUN: begin
        if (mem_busy) begin
          state_nxt    = WAIT;
          wait_ctr_nxt = CW'(1);
        end
      end
      WAIT: begin
        if (!mem_busy) begin
          state_nxt    = RUN;
          wait_ctr_nxt = '0;
        end else if (wait_ctr == CW'(MEM_TIMEOUT - 1)) begin
          state_nxt = ERR;
        end else begin
          wait_ctr_nxt = wait_ctr + CW'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  assign hold_all = (state == ERR) || mem_busy;
  assign load_use = ResultSrcE && RegWriteE && (RD_E != 5'd0) &&
                    ((RD_E == RS1_D) || (RD_E == RS2_D));
  assign err      = (state == ERR);

  // A taken branch holds off while E is stalled, and beats a load-use bubble.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      if (hold_all) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteE && (RD_E != 5'd0) && (RD_E == rs))
      return 2'b10;
    else if (RegWriteM && (RD_M != 5'd0) && (RD_M == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fa_nxt = fwd_sel(RS1_D);
  assign fb_nxt = fwd_sel(RS2_D);

  // Selects are computed while the instruction sits in D and consumed in its E cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ForwardAE <= 2'b00;
      ForwardBE <= 2'b00;
    end else if (hold_all) begin
      ForwardAE <= ForwardAE;
      ForwardBE <= ForwardBE;
    end else if (FlushE) begin
      ForwardAE <= 2'b00;
      ForwardBE <= 2'b00;
    end else begin
      ForwardAE <= fa_nxt;
      ForwardBE <= fb_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic inc_stall, inc_flush, inc_wait;

  assign inc_stall = !hold_all && !PCSrcE && load_use;
  assign inc_flush = !hold_all && PCSrcE;
  assign inc_wait  = hold_all && (state != ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (inc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (inc_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (inc_wait  && (wait_cnt  != '1)) wait_cnt  <= wait_cnt + 1'b1;
    end
  end
`endif

endmodule
